oam_dma: RTL and testbench

- Sprite OAM DMA engine sitting directly upstream of the PPU register port. It feeds OAMDATA writes into the PPU's OAM.
- A CPU write to $4014 latches a source page. The engine then halts the CPU via rdy and copies 256 bytes from $XX00-$XXFF to PPU register $2004.
- It owns the CPU-side bus only while dma_act is high.

---
 rtl/nes_pkg.sv | 15 +
 rtl/oam_dma_if.sv | 26 ++
 rtl/oam_dma.sv | 146 ++++++++++++++
 tb/tb_oam_dma.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES bus constants and the OAM DMA state type.
package nes_pkg;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [2:0]  OAMDATA_ADDR = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side bus seen by the OAM DMA engine: CPU cycle inputs in, DMA bus drive out.
interface oam_dma_if;

  logic        cpu_ce;
  logic [15:0] cpu_addr_i;
  logic        cpu_rw_i;
  logic [7:0]  cpu_data_i;
  logic [7:0]  bus_data_i;
  logic        rdy;
  logic        dma_act;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_data_o;
  logic        dma_done;

  modport slave (
    input  cpu_ce, cpu_addr_i, cpu_rw_i, cpu_data_i, bus_data_i,
    output rdy, dma_act, dma_addr, dma_rw, dma_data_o, dma_done
  );

  modport master (
    output cpu_ce, cpu_addr_i, cpu_rw_i, cpu_data_i, bus_data_i,
    input  rdy, dma_act, dma_addr, dma_rw, dma_data_o, dma_done
  );

endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a $4014 write halts the CPU and copies one 256-byte page to $2004.
// Optional OAM_DMA_RD_HALT_EN: stay in HALT until the CPU issues a read cycle.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] OAMDATA_REG = 16'h2004,
  parameter int          XFER_LEN    = 256
) (
  input logic      clk,
  input logic      rst_n,
  oam_dma_if.slave bus
);

  localparam int CNT_W = $clog2(XFER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_LEN - 1);

  dma_state_t     state_q, state_d;
  logic [7:0]     page_q, page_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           parity_q, parity_d;
  logic           rdy_q, rdy_d;
  logic           act_q, act_d;
  logic [15:0]    addr_q, addr_d;
  logic           rw_q, rw_d;
  logic [7:0]     data_q, data_d;
  logic           done_q, done_d;
  logic           trigger_s;
  logic           halt_go_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign trigger_s = (bus.cpu_addr_i == OAMDMA_ADDR) && (bus.cpu_rw_i == 1'b0);
  assign cnt_inc_s = cnt_q + CNT_W'(1);

`ifdef OAM_DMA_RD_HALT_EN
  // The 6502 only honours rdy on a read, so hold HALT until one arrives.
  assign halt_go_s = bus.cpu_rw_i;
`else
  assign halt_go_s = 1'b1;
`endif

  // Next-state and next-output logic; everything advances only on a CPU cycle strobe.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    rdy_d    = rdy_q;
    act_d    = act_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    data_d   = data_q;
    done_d   = 1'b0;
    if (bus.cpu_ce) begin
      parity_d = ~parity_q;
      case (state_q)
        IDLE: begin
          if (trigger_s) begin
            page_d  = bus.cpu_data_i;
            rdy_d   = 1'b0;
            state_d = HALT;
          end else begin
            state_d = IDLE;
          end
        end
        HALT: begin
          if (halt_go_s) begin
            act_d   = 1'b1;
            rw_d    = 1'b1;
            addr_d  = {page_q, cnt_q};
            // Reads must land on get cycles; a get-cycle HALT needs one dummy read first.
            state_d = parity_q ? READ : ALIGN;
          end else begin
            state_d = HALT;
          end
        end
        ALIGN: begin
          state_d = READ;
        end
        READ: begin
          data_d  = bus.bus_data_i;
          rw_d    = 1'b0;
          addr_d  = OAMDATA_REG;
          state_d = WRITE;
        end
        WRITE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
            act_d   = 1'b0;
            rw_d    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_inc_s;
            rw_d    = 1'b1;
            addr_d  = {page_q, cnt_inc_s};
            state_d = READ;
          end
        end
        default: begin
          rdy_d   = 1'b1;
          act_d   = 1'b0;
          rw_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      rdy_q    <= 1'b1;
      act_q    <= 1'b0;
      addr_q   <= 16'h0000;
      rw_q     <= 1'b1;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      rdy_q    <= rdy_d;
      act_q    <= act_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign bus.rdy        = rdy_q;
  assign bus.dma_act    = act_q;
  assign bus.dma_addr   = addr_q;
  assign bus.dma_rw     = rw_q;
  assign bus.dma_data_o = data_q;
  assign bus.dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: transfer-index model compared every clock, plus literal checks.
module tb_oam_dma;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oam_dma_if bif();

  oam_dma #(.OAMDATA_REG(16'h2004), .XFER_LEN(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  logic [7:0] salt = 8'h00;

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input logic [7:0] s);
    return a[7:0] ^ 8'hA5 ^ s;
  endfunction

  assign bif.bus_data_i = mem_byte(bif.dma_addr, salt);

  int n_chk   = 0;
  int n_fail  = 0;
  int gap     = 1;
  int rdy_low = 0;
  int n_ce    = 0;
  int done_cnt = 0;
  int clk_cnt = 0;
  logic [15:0] last_rd = 16'h0000;
  logic [7:0]  last_wr = 8'h00;

  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Model: position in the 512(+1) bus-cycle sequence after HALT; -1 idle, -2 halted.
  logic        x_rdy = 1'b1, x_act = 1'b0, x_rw = 1'b1, x_done = 1'b0;
  logic [15:0] x_addr = 16'h0000;
  logic [7:0]  x_data = 8'h00;
  int          m_pos = -1;
  int          m_align = 0;
  bit          m_par = 1'b0;
  logic [7:0]  m_page = 8'h00;

`ifdef OAM_DMA_RD_HALT_EN
  localparam int EXP_HALT = 4;
`else
  localparam int EXP_HALT = 1;
`endif

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    x_rdy = 1'b1; x_act = 1'b0; x_rw = 1'b1; x_done = 1'b0;
    x_addr = 16'h0000; x_data = 8'h00;
    m_pos = -1; m_par = 1'b0; m_page = 8'h00;
  endtask

  task automatic model_apply();
    int t;
    logic [7:0] b;
    t = m_pos - m_align;
    x_act = 1'b1;
    if (t < 0) begin
      x_rw = 1'b1; x_addr = {m_page, 8'h00};
    end else begin
      b = 8'(t / 2);
      if (t % 2 == 0) begin
        x_rw = 1'b1; x_addr = {m_page, b};
      end else begin
        x_rw = 1'b0; x_addr = 16'h2004; x_data = mem_byte({m_page, b}, salt);
      end
    end
  endtask

  task automatic model_step(input logic [15:0] a, input logic rw, input logic [7:0] d);
    bit go;
`ifdef OAM_DMA_RD_HALT_EN
    go = rw;
`else
    go = 1'b1;
`endif
    if (m_pos == -1) begin
      if (a == 16'h4014 && rw == 1'b0) begin
        m_page = d; m_pos = -2; x_rdy = 1'b0;
      end
    end else if (m_pos == -2) begin
      if (go) begin
        m_align = (m_par == 1'b0) ? 1 : 0;
        m_pos = 0;
        model_apply();
      end
    end else begin
      m_pos++;
      if (m_pos == 512 + m_align) begin
        x_done = 1'b1; x_rdy = 1'b1; x_act = 1'b0; x_rw = 1'b1; m_pos = -1;
      end else begin
        model_apply();
      end
    end
    m_par = !m_par;
  endtask

  task automatic cmp_cycle();
    check("rdy",      32'(bif.rdy),        32'(x_rdy));
    check("dma_act",  32'(bif.dma_act),    32'(x_act));
    check("dma_addr", 32'(bif.dma_addr),   32'(x_addr));
    check("dma_rw",   32'(bif.dma_rw),     32'(x_rw));
    check("dma_data", 32'(bif.dma_data_o), 32'(x_data));
    check("dma_done", 32'(bif.dma_done),   32'(x_done));
    if (bif.dma_done) done_cnt++;
    if (bif.dma_act && bif.dma_rw) last_rd = bif.dma_addr;
    if (bif.dma_act && !bif.dma_rw) last_wr = bif.dma_data_o;
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic strobe(input logic [15:0] a, input logic rw, input logic [7:0] d, output bit saw_done);
    if (!bif.rdy) rdy_low++;
    bif.cpu_addr_i = a; bif.cpu_rw_i = rw; bif.cpu_data_i = d; bif.cpu_ce = 1'b1;
    n_ce++;
    model_step(a, rw, d);
    tick();
    saw_done = bif.dma_done;
    bif.cpu_ce = 1'b0;
    x_done = 1'b0;
    for (int i = 1; i < gap; i++) tick();
  endtask

  task automatic run_to_done(input string nm);
    bit d;
    int k;
    int base;
    base = done_cnt;
    d = 1'b0; k = 0;
    while (!d && k < 600) begin
      strobe(16'h8000, 1'b1, 8'h00, d);
      k++;
    end
    check({nm, "_done_seen"}, 32'(d), 32'd1);
    for (int i = 0; i < 4; i++) strobe(16'h8001, 1'b1, 8'h00, d);
    check({nm, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.cpu_ce = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bit dd;
    bit found;
    int k;
    int c0;
    int n0;
    bif.cpu_ce = 1'b0; bif.cpu_addr_i = 16'h0000; bif.cpu_rw_i = 1'b1; bif.cpu_data_i = 8'h00;
    model_reset();
    tick();
    tick();
    check("rst_rdy",  32'(bif.rdy),        32'd1);
    check("rst_act",  32'(bif.dma_act),    32'd0);
    check("rst_addr", 32'(bif.dma_addr),   32'h0000);
    check("rst_rw",   32'(bif.dma_rw),     32'd1);
    check("rst_data", 32'(bif.dma_data_o), 32'h00);
    check("rst_done", 32'(bif.dma_done),   32'd0);
    rst_n = 1'b1;
    tick();

    // HALT on a put cycle: straight to READ, 513 halted cycles.
    salt = 8'h00;
    rdy_low = 0;
    strobe(16'h4014, 1'b0, 8'h02, dd);
    strobe(16'h8000, 1'b1, 8'h00, dd);
    check("noalign_first_addr", 32'(bif.dma_addr), 32'h0200);
    check("noalign_first_rw",   32'(bif.dma_rw),   32'd1);
    strobe(16'h8000, 1'b1, 8'h00, dd);
    check("noalign_write_rw",   32'(bif.dma_rw),   32'd0);
    run_to_done("noalign");
    check("noalign_rdy_low", 32'(rdy_low), 32'd513);

    // HALT on a get cycle: one dummy ALIGN read, 514 halted cycles.
    do_reset();
    salt = 8'h5C;
    strobe(16'h8000, 1'b1, 8'h00, dd);
    rdy_low = 0;
    strobe(16'h4014, 1'b0, 8'h02, dd);
    strobe(16'h8000, 1'b1, 8'h00, dd);
    check("align_addr",  32'(bif.dma_addr), 32'h0200);
    check("align_rw",    32'(bif.dma_rw),   32'd1);
    check("align_act",   32'(bif.dma_act),  32'd1);
    strobe(16'h8000, 1'b1, 8'h00, dd);
    check("align_read_addr", 32'(bif.dma_addr), 32'h0200);
    check("align_read_rw",   32'(bif.dma_rw),   32'd1);
    run_to_done("align");
    check("align_rdy_low", 32'(rdy_low), 32'd514);

    // Top page: no wrap into page 00, counter restarts at 0 next time.
    do_reset();
    salt = 8'h00;
    strobe(16'h4014, 1'b0, 8'hFF, dd);
    run_to_done("pageff");
    check("pageff_last_rd", 32'(last_rd), 32'hFFFF);
    check("pageff_last_wr", 32'(last_wr), 32'h5A);
    strobe(16'h4014, 1'b0, 8'hFF, dd);
    strobe(16'h8000, 1'b1, 8'h00, dd);
    check("pageff_restart_addr", 32'(bif.dma_addr), 32'hFF00);
    run_to_done("pageff2");

    // Gapped strobes: one cpu_ce every third clock.
    do_reset();
    salt = 8'h3C;
    gap = 3;
    c0 = clk_cnt;
    n0 = n_ce;
    strobe(16'h4014, 1'b0, 8'h01, dd);
    run_to_done("gapped");
    check("gapped_clk_ratio", 32'(clk_cnt - c0), 32'(3 * (n_ce - n0)));
    gap = 1;

    // Reset in the middle of a transfer, then a clean transfer.
    do_reset();
    salt = 8'h11;
    strobe(16'h4014, 1'b0, 8'h01, dd);
    found = 1'b0; k = 0;
    while (!found && k < 400) begin
      strobe(16'h8000, 1'b1, 8'h00, dd);
      found = bif.dma_act && (bif.dma_addr == 16'h0140);
      k++;
    end
    check("midrst_reached_0140", 32'(found), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_rdy", 32'(bif.rdy),     32'd1);
    check("midrst_act", 32'(bif.dma_act), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rdy_low = 0;
    strobe(16'h4014, 1'b0, 8'h03, dd);
    run_to_done("after_rst");
    check("after_rst_rdy_low", 32'(rdy_low), 32'd513);
    check("after_rst_last_rd", 32'(last_rd), 32'h03FF);

    // CPU writes (including a stray $4014) right after the trigger.
    do_reset();
    salt = 8'h77;
    strobe(16'h4014, 1'b0, 8'h02, dd);
    found = 1'b0; k = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      strobe(16'h4014, 1'b0, 8'h77, dd);
      k++;
      found = bif.dma_act;
    end
    while (!found && k < 8) begin
      strobe(16'h8000, 1'b1, 8'h00, dd);
      k++;
      found = bif.dma_act;
    end
    check("halt_len", 32'(k), 32'(EXP_HALT));
    check("halt_page_kept", 32'(bif.dma_addr), 32'h0200);
    run_to_done("halt_wr");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
